// File: rtl/serial_sum_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_sum_splitter: recovers b = s - a bit-serially (LSB first) behind  |
// | valid/ready handshakes, flagging pairs with no legal b.   Rev 1.0        |
// +--------------------------------------------------------------------------+
module serial_sum_splitter #(
  parameter int AW = 4,
  parameter int SW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] s,
  input  logic [AW-1:0] a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] b,
  output logic          err
);

  localparam int CNT_W = $clog2(SW + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(SW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [SW-1:0]    r_s,         w_s_nxt;
  logic [SW-1:0]    r_a,         w_a_nxt;
  logic [SW-1:0]    r_diff,      w_diff_nxt;
  logic             r_borrow,    w_borrow_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [AW-1:0]    r_b,         w_b_nxt;
  logic             r_err,       w_err_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             w_dbit;
  logic             w_borrow_bit;

  assign w_dbit       = r_s[0] ^ r_a[0] ^ r_borrow;
  assign w_borrow_bit = (~r_s[0] & (r_a[0] | r_borrow)) | (r_a[0] & r_borrow & r_s[0]);

  always_comb begin
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_a_nxt         = r_a;
    w_diff_nxt      = r_diff;
    w_borrow_nxt    = r_borrow;
    w_cnt_nxt       = r_cnt;
    w_b_nxt         = r_b;
    w_err_nxt       = r_err;
    w_out_valid_nxt = r_out_valid;
    w_in_ready_nxt  = r_in_ready;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_s_nxt        = s;
          w_a_nxt        = SW'(a);
          w_borrow_nxt   = 1'b0;
          w_cnt_nxt      = '0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        // Operands rotate rather than shift so they return intact after SW steps.
        w_s_nxt      = {r_s[0], r_s[SW-1:1]};
        w_a_nxt      = {r_a[0], r_a[SW-1:1]};
        w_diff_nxt   = {w_dbit, r_diff[SW-1:1]};
        w_borrow_nxt = w_borrow_bit;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == c_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!r_out_valid) begin
          w_b_nxt         = r_diff[AW-1:0];
          w_err_nxt       = r_borrow | r_diff[SW-1];
          w_out_valid_nxt = 1'b1;
        end else if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_a         <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_b         <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_a         <= w_a_nxt;
      r_diff      <= w_diff_nxt;
      r_borrow    <= w_borrow_nxt;
      r_cnt       <= w_cnt_nxt;
      r_b         <= w_b_nxt;
      r_err       <= w_err_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_state == DONE && r_out_valid && !r_err) begin
      assert ((r_a + SW'(r_b)) == r_s)
        $info("serial_sum_splitter: Pass a+b==s (a=%0d b=%0d s=%0d)", r_a, r_b, r_s);
      else
        $error("serial_sum_splitter: a+b!=s (a=%0d b=%0d s=%0d)", r_a, r_b, r_s);
    end
    if (rst_n) begin
      assert (!(r_out_valid && r_in_ready))
        else $error("serial_sum_splitter: out_valid and in_ready both high");
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign b         = r_b;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_sum_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_sum_splitter: directed scenarios with hand-computed results.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_serial_sum_splitter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] s;
  logic [3:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] b;
  logic       err;

  int total = 0;
  int bad   = 0;

  serial_sum_splitter #(.AW(4), .SW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation from IDLE, return result and edges from accept to out_valid.
  task automatic do_op(input logic [4:0] sv, input logic [3:0] av,
                       output logic [3:0] bo, output logic eo, output int lat);
    s = sv;
    a = av;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    bo = b;
    eo = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = '0; a = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (b !== 4'd0) begin bad++; $display("FAIL reset_b got=%0d want=0", b); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    logic [3:0] bo; logic eo; int lat;
    do_op(5'd20, 4'd7, bo, eo, lat);
    total++; if (lat != 6) begin bad++; $display("FAIL nominal_latency got=%0d want=6", lat); end
    total++; if (bo !== 4'd13) begin bad++; $display("FAIL nominal_b got=%0d want=13", bo); end
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL nominal_err got=%b want=0", eo); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nominal_drop_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nominal_ready_back got=%b want=1", in_ready); end
  endtask

  task automatic test_underflow();
    logic [3:0] bo; logic eo; int lat;
    do_op(5'd3, 4'd5, bo, eo, lat);
    total++; if (bo !== 4'd14) begin bad++; $display("FAIL underflow_b got=%0d want=14", bo); end
    total++; if (eo !== 1'b1) begin bad++; $display("FAIL underflow_err got=%b want=1", eo); end
  endtask

  task automatic test_boundaries();
    logic [3:0] bo; logic eo; int lat;
    do_op(5'd31, 4'd0, bo, eo, lat);
    total++; if (bo !== 4'd15) begin bad++; $display("FAIL overflow_b got=%0d want=15", bo); end
    total++; if (eo !== 1'b1) begin bad++; $display("FAIL overflow_err got=%b want=1", eo); end
    do_op(5'd30, 4'd15, bo, eo, lat);
    total++; if (bo !== 4'd15) begin bad++; $display("FAIL max_legal_b got=%0d want=15", bo); end
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL max_legal_err got=%b want=0", eo); end
    do_op(5'd0, 4'd0, bo, eo, lat);
    total++; if (bo !== 4'd0) begin bad++; $display("FAIL zero_b got=%0d want=0", bo); end
    total++; if (eo !== 1'b0) begin bad++; $display("FAIL zero_err got=%b want=0", eo); end
  endtask

  task automatic test_backpressure_busy();
    int lat;
    s = 5'd12; a = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    // New operands offered mid-computation must be ignored.
    s = 5'd31; a = 4'd1; in_valid = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b want=0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 3;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat != 6) begin bad++; $display("FAIL busy_latency got=%0d want=6", lat); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || b !== 4'd7 || err !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d got valid=%b b=%0d err=%b want valid=1 b=7 err=0", i, out_valid, b, err);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [3:0] bo; logic eo; int lat;
    int seen;
    s = 5'd20; a = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || b !== 4'd0 || err !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got ready=%b valid=%b b=%0d err=%b want 1 0 0 0", in_ready, out_valid, b, err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_no_emit got=%0d want=0", seen); end
    do_op(5'd9, 4'd4, bo, eo, lat);
    total++; if (bo !== 4'd5 || eo !== 1'b0) begin
      bad++; $display("FAIL after_reset_op got b=%0d err=%b want b=5 err=0", bo, eo);
    end
  endtask

  task automatic test_random();
    logic [3:0] bo; logic eo; int lat;
    logic [3:0] av, bv;
    for (int i = 0; i < 10; i++) begin
      av = 4'($urandom_range(15, 0));
      bv = 4'($urandom_range(15, 0));
      do_op(5'(av) + 5'(bv), av, bo, eo, lat);
      total++; if (bo !== bv || eo !== 1'b0 || lat != 6) begin
        bad++; $display("FAIL random%0d a=%0d got b=%0d err=%b lat=%0d want b=%0d err=0 lat=6", i, av, bo, eo, lat, bv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underflow();
    test_boundaries();
    test_backpressure_busy();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_sum_splitter.md
Name: serial_sum_splitter

Overview:
- Inverse of the team's combinational adder: given a sum `s` and one addend `a`, recovers the other addend `b = s - a`.
- Computes bit-serially, LSB first, one bit per clock, using a borrow flop.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Flags operand pairs with no legal `b`. Sits downstream of adder result buses in the arithmetic test fabric.

Parameters:
- AW, 4, width of addends `a` and `b`.
- SW, AW+1, width of sum `s`; must equal AW+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on `s`/`a`.
- in_ready  output  1  block can accept operands.
- s  input  SW  sum operand.
- a  input  AW  known addend.
- out_valid  output  1  result on `b`/`err` is valid.
- out_ready  input  1  consumer takes the result.
- b  output  AW  recovered addend.
- err  output  1  no b in [0, 2^AW-1] satisfies a+b==s.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, b=0, err=0, borrow=0, bit counter=0. All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch s (zero-extend a to SW bits), clear borrow and counter, go to SHIFT. in_ready drops the cycle after acceptance.
- SHIFT:
  - Each edge computes one difference bit, diff[i] = s[i]^a[i]^borrow.
  - Next borrow = (~s[i]&(a[i]|borrow)) | (a[i]&borrow&s[i]).
  - The difference shifts into a SW-bit result register. The counter increments.
  - After exactly SW SHIFT edges, go to DONE.
  - in_valid is ignored in SHIFT and DONE, with no side effects.
- DONE:
  - out_valid=1, b=diff[AW-1:0].
  - err = final_borrow | diff[SW-1]: either s<a, or s-a > 2^AW-1.
  - b, err and out_valid hold stable while out_ready=0.
  - On out_valid&&out_ready at an edge: out_valid drops, return to IDLE, in_ready=1 the next cycle. No same-cycle re-accept.
- Latency: out_valid is asserted SW+1 edges after the accepting edge (5+1 = 6 at defaults). Throughput is one operation per SW+3 cycles minimum.
- Reset mid-operation (any state) aborts immediately to reset values. The partial result is discarded and nothing is emitted.
- Embedded immediate assertion, evaluated in DONE when err=0: `(a_latched + b) == s_latched`. Reports $info on pass, $error on fail.
- Second assertion: out_valid and in_ready are never both 1.
- Arithmetic wraps modulo 2^SW internally. b always carries the low AW bits of that wrapped difference, even when err=1.

Test Plan:
- Nominal: s=20, a=7 -> b=13, err=0. out_valid rises 6 edges after acceptance. Assertion prints Pass.
- Underflow: s=3, a=5 -> err=1, b=14 (the wrapped difference 30 has low bits 1110).
- Overflow: s=31, a=0 -> err=1, b=15. Boundary: s=30, a=15 -> b=15, err=0. Also s=0, a=0 -> b=0, err=0.
- Backpressure and busy: hold out_ready=0 for 4 cycles in DONE -> b, err and out_valid are stable. Pulse in_valid with new operands during SHIFT -> ignored; the result matches the first operands.
- Reset mid-SHIFT: drop rst_n at bit 2 -> all outputs at reset values immediately; out_valid never rises. A subsequent s=9, a=4 gives b=5.
- Random: 10 random (a,b) pairs with s=a+b -> recovered b equals the original, err=0 every time, and no assertion failures.
